// File: rtl/memory_master.sv
// Four-phase handshake master bridging a valid/ready request port to an
// asynchronous enable/ack memory; ack is synchronized before any use.
`timescale 1ns/1ps
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif

module memory_master #(
    parameter int WIDTH       = `MEMORY_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [31:0]        req_addr,
    input  logic [WIDTH/8-1:0] req_byte_enable,
    input  logic [WIDTH-1:0]   req_data,
    output logic               resp_valid,
    output logic               resp_error,
    output logic [WIDTH-1:0]   resp_data,
    output logic [31:0]        mem_addr,
    output logic               mem_enable,
    output logic               mem_read_write,
    output logic [WIDTH/8-1:0] mem_byte_enable,
    output logic [WIDTH-1:0]   mem_data_out,
    input  logic [WIDTH-1:0]   mem_data_in,
    input  logic               mem_ack
);

    localparam int BYTES = WIDTH / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ASSERT,
        RELEASE,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   settled_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   timed_out;

    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_error_q, resp_error_d;
    logic [WIDTH-1:0]       resp_data_q, resp_data_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic                   mem_enable_q, mem_enable_d;
    logic                   mem_read_write_q, mem_read_write_d;
    logic [BYTES-1:0]       mem_byte_enable_q, mem_byte_enable_d;
    logic [WIDTH-1:0]       mem_data_out_q, mem_data_out_d;

    // mem_ack is only ever seen through this chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value.
            sync_q <= {sync_q[SYNC_STAGES-2:0], mem_ack};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d           = state_q;
        cnt_d             = cnt_q;
        err_d             = err_q;
        resp_valid_d      = 1'b0;
        resp_error_d      = 1'b0;
        resp_data_d       = resp_data_q;
        mem_addr_d        = mem_addr_q;
        mem_enable_d      = mem_enable_q;
        mem_read_write_d  = mem_read_write_q;
        mem_byte_enable_d = mem_byte_enable_q;
        mem_data_out_d    = mem_data_out_q;
        timed_out         = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    mem_addr_d        = req_addr;
                    mem_read_write_d  = ~req_write;
                    mem_byte_enable_d = req_byte_enable;
                    mem_data_out_d    = req_data;
                    err_d             = 1'b0;
                    state_d           = SETUP;
                end
            end
            SETUP: begin
                mem_enable_d = 1'b1;
                cnt_d        = '0;
                state_d      = ASSERT;
            end
            ASSERT: begin
                if (ack_s) begin
                    if (mem_read_write_q) resp_data_d = mem_data_in;
                    mem_enable_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = RELEASE;
                end else if (timed_out) begin
                    mem_enable_d = 1'b0;
                    err_d        = 1'b1;
                    cnt_d        = '0;
                    state_d      = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    resp_valid_d = 1'b1;
                    resp_error_d = err_q;
                    state_d      = DONE;
                end else if (timed_out) begin
                    err_d        = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Ready waits until no ack is anywhere in the chain, including just after reset.
        req_ready_d = (state_d == IDLE) && settled_q && (sync_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: reset touches control and datapath registers alike; there is no storage array here.
            state_q           <= IDLE;
            settled_q         <= 1'b0;
            cnt_q             <= '0;
            err_q             <= 1'b0;
            req_ready_q       <= 1'b0;
            resp_valid_q      <= 1'b0;
            resp_error_q      <= 1'b0;
            resp_data_q       <= '0;
            mem_addr_q        <= '0;
            mem_enable_q      <= 1'b0;
            mem_read_write_q  <= 1'b1;
            mem_byte_enable_q <= '0;
            mem_data_out_q    <= '0;
        end else begin
            state_q           <= state_d;
            settled_q         <= 1'b1;
            cnt_q             <= cnt_d;
            err_q             <= err_d;
            req_ready_q       <= req_ready_d;
            resp_valid_q      <= resp_valid_d;
            resp_error_q      <= resp_error_d;
            resp_data_q       <= resp_data_d;
            mem_addr_q        <= mem_addr_d;
            mem_enable_q      <= mem_enable_d;
            mem_read_write_q  <= mem_read_write_d;
            mem_byte_enable_q <= mem_byte_enable_d;
            mem_data_out_q    <= mem_data_out_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_error      = resp_error_q;
    assign resp_data       = resp_data_q;
    assign mem_addr        = mem_addr_q;
    assign mem_enable      = mem_enable_q;
    assign mem_read_write  = mem_read_write_q;
    assign mem_byte_enable = mem_byte_enable_q;
    assign mem_data_out    = mem_data_out_q;

endmodule

// File: tb/tb_memory_master.sv
// Scoreboard bench for memory_master: a behavioural memory responder with
// programmable ack latency, a reference word model and a response monitor.
`timescale 1ns/1ps

module tb_memory_master;

    localparam int WIDTH   = 32;
    localparam int BYTES   = WIDTH / 8;
    localparam int SYNC    = 2;
    localparam int TMO     = 8;
    localparam int LAT0    = 3 + 2 * SYNC;
    localparam int LAT_TMO = TMO + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready, req_write;
    logic [31:0]      req_addr;
    logic [BYTES-1:0] req_byte_enable;
    logic [WIDTH-1:0] req_data;
    logic             resp_valid, resp_error;
    logic [WIDTH-1:0] resp_data;
    logic [31:0]      mem_addr;
    logic             mem_enable, mem_read_write;
    logic [BYTES-1:0] mem_byte_enable;
    logic [WIDTH-1:0] mem_data_out, mem_data_in;
    logic             mem_ack;

    memory_master #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_byte_enable(req_byte_enable), .req_data(req_data),
        .resp_valid(resp_valid), .resp_error(resp_error), .resp_data(resp_data),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_read_write(mem_read_write),
        .mem_byte_enable(mem_byte_enable), .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             err;
        int               acc_cyc;
        int               lat;   // -1: latency not checked
    } exp_t;

    exp_t             exp_q[$];
    exp_t             me;
    int               n_total = 0;
    int               n_pass  = 0;
    logic [WIDTH-1:0] resp_mem [0:15];
    logic [WIDTH-1:0] ref_mem  [0:15];
    logic [WIDTH-1:0] last_rd = '0;
    logic [68:0]      cur_vec = '0;
    int               lat_ns = 0;
    bit               no_ack = 1'b0;
    bit               abort_flag = 1'b0;
    bit               pulse_chk = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Memory responder: four-phase slave, ack delayed by lat_ns after seeing enable change.
    initial begin
        mem_ack     = 1'b0;
        mem_data_in = '0;
        forever begin
            do @(negedge clk); while (!(mem_enable && !no_ack));
            #(lat_ns);
            if (mem_read_write) mem_data_in = resp_mem[mem_addr[5:2]];
            else
                for (int b = 0; b < BYTES; b++)
                    if (mem_byte_enable[b]) resp_mem[mem_addr[5:2]][8*b +: 8] = mem_data_out[8*b +: 8];
            check("cmd_at_ack", {mem_addr, mem_read_write, mem_byte_enable, mem_data_out}, cur_vec);
            check("ready_low_busy", req_ready, 1'b0);
            mem_ack = 1'b1;
            do @(negedge clk); while (mem_enable);
            #(lat_ns);
            mem_ack = 1'b0;
            if (abort_flag) begin
                abort_flag = 1'b0;
            end else begin
                repeat (SYNC) @(negedge clk);
                check("cmd_stable", {mem_addr, mem_read_write, mem_byte_enable, mem_data_out}, cur_vec);
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (pulse_chk) begin
            check("pulse_one_cycle", resp_valid, 1'b0);
            check("error_idle", resp_error, 1'b0);
            pulse_chk = 1'b0;
        end else if (resp_valid) begin
            check("resp_outstanding", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                me = exp_q.pop_front();
                check("resp_data", resp_data, me.data);
                check("resp_error", resp_error, me.err);
                if (me.lat >= 0) check("latency", cyc - me.acc_cyc, me.lat);
            end
            pulse_chk = 1'b1;
        end
    end

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [BYTES-1:0] be,
                         input logic [WIDTH-1:0] data, input int lat, input bit noack);
        exp_t e;
        int   idx;
        @(negedge clk);
        lat_ns          = lat;
        no_ack          = noack;
        req_write       = wr;
        req_addr        = addr;
        req_byte_enable = be;
        req_data        = data;
        req_valid       = 1'b1;
        for (int i = 0; i < 300 && !req_ready; i++) @(negedge clk);
        check("ready_wait", req_ready, 1'b1);
        check("one_outstanding", exp_q.size(), 0);
        idx       = int'(addr[5:2]);
        e.acc_cyc = cyc + 1;
        e.err     = 1'b0;
        e.lat     = (lat == 0) ? LAT0 : -1;
        if (noack) begin
            e.err  = 1'b1;
            e.data = last_rd;
            e.lat  = LAT_TMO;
        end else if (!wr) begin
            e.data  = ref_mem[idx];
            last_rd = ref_mem[idx];
        end else begin
            for (int b = 0; b < BYTES; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
            e.data = last_rd;
        end
        cur_vec = {addr, ~wr, be, data};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] v;
        reset           = 1'b1;
        req_valid       = 1'b0;
        req_write       = 1'b0;
        req_addr        = '0;
        req_byte_enable = '0;
        req_data        = '0;
        for (int i = 0; i < 16; i++) begin
            v           = $urandom;
            resp_mem[i] = v;
            ref_mem[i]  = v;
        end
        resp_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]  = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        check("rst_mem_enable", mem_enable, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_error", resp_error, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_mem_rw", mem_read_write, 1'b1);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst_edge", req_ready, 1'b0);

        // Zero-latency read, write with partial lanes, read-back.
        issue(1'b0, 32'h10, 4'hF, '0, 0, 1'b0);
        drain();
        issue(1'b1, 32'h4, 4'b0011, 32'h1122_3344, 0, 1'b0);
        drain();
        issue(1'b0, 32'h4, 4'hF, '0, 0, 1'b0);
        drain();

        // Responder never acks: timeout path.
        issue(1'b0, 32'h8, 4'hF, '0, 0, 1'b1);
        drain();

        // Slow responder.
        issue(1'b0, 32'hC, 4'hF, '0, 50, 1'b0);
        drain();

        // Reset while ASSERT holds with ack high.
        issue(1'b0, 32'h20, 4'hF, '0, 50, 1'b0);
        req_valid = 1'b0;
        for (int i = 0; i < 40 && !mem_ack; i++) @(posedge clk);
        check("ack_before_reset", mem_ack, 1'b1);
        #2;
        abort_flag = 1'b1;
        reset      = 1'b1;
        exp_q.delete();
        last_rd    = '0;
        #1;
        check("reset_drops_enable", mem_enable, 1'b0);
        check("reset_resp_valid", resp_valid, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_low_ack_high", req_ready, 1'b0);
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        check("ready_returns", req_ready, 1'b1);
        check("ack_low_at_ready", mem_ack, 1'b0);
        issue(1'b0, 32'h10, 4'hF, '0, 0, 1'b0);
        drain();

        // Back-to-back reads with req_valid held.
        issue(1'b0, 32'h14, 4'hF, '0, 0, 1'b0);
        issue(1'b0, 32'h18, 4'hF, '0, 0, 1'b0);
        drain();

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            issue(1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                  4'($urandom), $urandom, 10 * $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
